// File: rtl/mipi_csi_rx_pkg.sv
// Shared definitions for the CSI-2 RX virtual-channel stream controller:
// data-type codes, the frame sync state encoding and the GSP FIFO entry.
package mipi_csi_rx_pkg;

  localparam logic [5:0] DT_FS       = 6'h00;
  localparam logic [5:0] DT_FE       = 6'h01;
  localparam logic [5:0] DT_LS       = 6'h02;
  localparam logic [5:0] DT_LE       = 6'h03;
  localparam logic [5:0] DT_GSP_BASE = 6'h08;
  localparam logic [5:0] DT_EMB      = 6'h12;

  typedef enum logic [1:0] {
    SYNC_IDLE      = 2'd0,
    SYNC_IN_FRAME  = 2'd1,
    SYNC_OUT_FRAME = 2'd2
  } sync_state_t;

  typedef struct packed {
    logic [2:0]  code;
    logic [15:0] value;
  } gsp_entry_t;

  // Generic short packets occupy 0x08..0x0F, i.e. the upper three bits match the base.
  function automatic logic is_gsp(input logic [5:0] dt);
    return dt[5:3] == DT_GSP_BASE[5:3];
  endfunction

endpackage

// File: rtl/mipi_csi_rx_gsp_fifo.sv
// First-word fall-through queue of generic short packets for one stream.
// A push into a full queue is dropped and reported, unless a pop frees a slot in the same cycle.
module mipi_csi_rx_gsp_fifo
  import mipi_csi_rx_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = gsp_entry_t
) (
  input  logic   clk_i,
  input  logic   reset_n_i,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  input  logic   flush_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o,
  output logic   overflow_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic          do_push;
  logic          do_pop;

  assign empty_o    = (wr_ptr_r == rd_ptr_r);
  assign full_o     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop     = pop_i & ~empty_o;
  assign do_push    = push_i & (~full_o | do_pop);
  assign overflow_o = push_i & full_o & ~do_pop;
  assign head_o     = mem[rd_ptr_r[AW-1:0]];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (flush_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop)  rd_ptr_r <= rd_ptr_r + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (do_push && !flush_i) begin
      mem[wr_ptr_r[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/mipi_csi_rx_vc_stream_controller.sv
// Routes decoded CSI-2 packet headers to NUM_STREAMS virtual-channel streams, tracking
// frame/line state, sync and payload errors, and queueing generic short packets per stream.
module mipi_csi_rx_vc_stream_controller
  import mipi_csi_rx_pkg::*;
#(
  parameter int NUM_STREAMS = 4,
  parameter int VC_W        = 4,
  parameter int GSP_DEPTH   = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      packet_header_valid_i,
  input  logic [15:0]               packet_length_i,
  input  logic [VC_W-1:0]           vc_id_i,
  input  logic [5:0]                data_type_i,
  input  logic                      err_crc_i,
  input  logic                      err_sot_sync_hs_i,
  input  logic                      err_ecc_double_i,
  input  logic [NUM_STREAMS-1:0]    stream_enable_i,
  input  logic [NUM_STREAMS*VC_W-1:0] vc_id_reg_i,
  input  logic [NUM_STREAMS*6-1:0]  data_type_reg_i,
  input  logic [NUM_STREAMS-1:0]    clear_frame_sync_i,
  input  logic [NUM_STREAMS-1:0]    clear_frame_data_i,
  input  logic [NUM_STREAMS-1:0]    clear_gsp_ovf_i,
  input  logic [NUM_STREAMS-1:0]    gsp_pop_i,
  output logic [NUM_STREAMS-1:0]    activate_stream_o,
  output logic [NUM_STREAMS-1:0]    frame_valid_o,
  output logic [NUM_STREAMS-1:0]    line_valid_o,
  output logic [NUM_STREAMS*16-1:0] frame_num_o,
  output logic [NUM_STREAMS*16-1:0] line_num_o,
  output logic [NUM_STREAMS-1:0]    err_frame_sync_o,
  output logic [NUM_STREAMS-1:0]    err_frame_data_o,
  output logic [NUM_STREAMS-1:0]    gsp_valid_o,
  output logic [NUM_STREAMS*3-1:0]  gsp_code_o,
  output logic [NUM_STREAMS*16-1:0] gsp_data_o,
  output logic [NUM_STREAMS-1:0]    gsp_ovf_o
);

  logic valid_r;
  logic hdr_evt;
  logic fatal_err;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) valid_r <= 1'b0;
    else            valid_r <= packet_header_valid_i;
  end

  // A header held valid across several cycles yields a single event on its rising edge.
  assign hdr_evt   = packet_header_valid_i & ~valid_r;
  assign fatal_err = err_sot_sync_hs_i | err_ecc_double_i;

  for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_stream
    logic        match;
    logic        evt;
    logic        evt_fs, evt_fe, evt_ls, evt_le, evt_gsp;
    sync_state_t state_r, state_n;
    logic        sync_err;
    logic        act_r;
    logic        frame_valid_r, line_valid_r;
    logic [15:0] frame_num_r, line_num_r;
    logic        err_sync_r, err_data_r, payload_err_r, ovf_r;
    gsp_entry_t  push_entry, head;
    logic        fifo_full, fifo_empty, fifo_ovf;

    assign match   = stream_enable_i[i] & (vc_id_i == vc_id_reg_i[i*VC_W +: VC_W]);
    assign evt     = hdr_evt & match;
    assign evt_fs  = evt & (data_type_i == DT_FS);
    assign evt_fe  = evt & (data_type_i == DT_FE);
    assign evt_ls  = evt & (data_type_i == DT_LS);
    assign evt_le  = evt & (data_type_i == DT_LE);
    assign evt_gsp = evt & is_gsp(data_type_i);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_r <= SYNC_IDLE;
      else            state_r <= state_n;
    end

    always_comb begin
      state_n  = state_r;
      sync_err = 1'b0;
      if (!stream_enable_i[i]) begin
        state_n = SYNC_IDLE;
      end else if (evt_fs) begin
        state_n  = SYNC_IN_FRAME;
        sync_err = (state_r == SYNC_IN_FRAME);
      end else if (evt_fe) begin
        state_n  = SYNC_OUT_FRAME;
        sync_err = (state_r != SYNC_IN_FRAME);
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        act_r         <= 1'b0;
        frame_valid_r <= 1'b0;
        line_valid_r  <= 1'b0;
        frame_num_r   <= '0;
        line_num_r    <= '0;
      end else begin
        act_r <= packet_header_valid_i & match &
                 ((data_type_i == data_type_reg_i[i*6 +: 6]) | (data_type_i == DT_EMB));
        if (!stream_enable_i[i]) begin
          frame_valid_r <= 1'b0;
          line_valid_r  <= 1'b0;
        end else begin
          if (evt_fs) begin
            frame_valid_r <= 1'b1;
            frame_num_r   <= packet_length_i;
            line_num_r    <= '0;
          end
          if (evt_fe) frame_valid_r <= 1'b0;
          // A zero line number in LS means "next line"; the 16-bit add wraps naturally.
          if (evt_ls) begin
            line_valid_r <= 1'b1;
            line_num_r   <= (packet_length_i != 16'd0) ? packet_length_i : line_num_r + 16'd1;
          end
          if (evt_le) line_valid_r <= 1'b0;
        end
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        err_sync_r    <= 1'b0;
        err_data_r    <= 1'b0;
        payload_err_r <= 1'b0;
        ovf_r         <= 1'b0;
      end else begin
        if (sync_err | fatal_err)        err_sync_r <= 1'b1;
        else if (clear_frame_sync_i[i])  err_sync_r <= 1'b0;

        if (evt_fe & (payload_err_r | (err_crc_i & act_r))) err_data_r <= 1'b1;
        else if (clear_frame_data_i[i])                     err_data_r <= 1'b0;

        if (!stream_enable_i[i] || evt_fe) payload_err_r <= 1'b0;
        else if (err_crc_i & act_r)        payload_err_r <= 1'b1;

        if (fifo_ovf)                ovf_r <= 1'b1;
        else if (clear_gsp_ovf_i[i]) ovf_r <= 1'b0;
      end
    end

    assign push_entry.code  = data_type_i[2:0];
    assign push_entry.value = packet_length_i;

    mipi_csi_rx_gsp_fifo #(
      .DEPTH   (GSP_DEPTH),
      .entry_t (gsp_entry_t)
    ) u_gsp_fifo (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .push_i      (evt_gsp),
      .push_data_i (push_entry),
      .pop_i       (gsp_pop_i[i]),
      .flush_i     (~stream_enable_i[i]),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .overflow_o  (fifo_ovf)
    );

    assign activate_stream_o[i]     = act_r;
    assign frame_valid_o[i]         = frame_valid_r;
    assign line_valid_o[i]          = line_valid_r;
    assign frame_num_o[i*16 +: 16]  = frame_num_r;
    assign line_num_o[i*16 +: 16]   = line_num_r;
    assign err_frame_sync_o[i]      = err_sync_r;
    assign err_frame_data_o[i]      = err_data_r;
    assign gsp_valid_o[i]           = ~fifo_empty;
    assign gsp_code_o[i*3 +: 3]     = head.code;
    assign gsp_data_o[i*16 +: 16]   = head.value;
    assign gsp_ovf_o[i]             = ovf_r;
  end

endmodule

// File: tb/tb_mipi_csi_rx_vc_stream_controller.sv
// Directed self-checking bench for the CSI-2 RX VC stream controller (4 streams, 4-bit VC, 8-deep GSP FIFOs).
module tb_mipi_csi_rx_vc_stream_controller;
  import mipi_csi_rx_pkg::*;

  localparam int NS = 4;
  localparam int VW = 4;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic            packet_header_valid_i;
  logic [15:0]     packet_length_i;
  logic [VW-1:0]   vc_id_i;
  logic [5:0]      data_type_i;
  logic            err_crc_i, err_sot_sync_hs_i, err_ecc_double_i;
  logic [NS-1:0]   stream_enable_i;
  logic [NS*VW-1:0] vc_id_reg_i;
  logic [NS*6-1:0] data_type_reg_i;
  logic [NS-1:0]   clear_frame_sync_i, clear_frame_data_i, clear_gsp_ovf_i, gsp_pop_i;
  logic [NS-1:0]   activate_stream_o, frame_valid_o, line_valid_o;
  logic [NS*16-1:0] frame_num_o, line_num_o, gsp_data_o;
  logic [NS-1:0]   err_frame_sync_o, err_frame_data_o, gsp_valid_o, gsp_ovf_o;
  logic [NS*3-1:0] gsp_code_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  mipi_csi_rx_vc_stream_controller #(.NUM_STREAMS(NS), .VC_W(VW), .GSP_DEPTH(8)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .packet_header_valid_i(packet_header_valid_i), .packet_length_i(packet_length_i),
    .vc_id_i(vc_id_i), .data_type_i(data_type_i), .err_crc_i(err_crc_i),
    .err_sot_sync_hs_i(err_sot_sync_hs_i), .err_ecc_double_i(err_ecc_double_i),
    .stream_enable_i(stream_enable_i), .vc_id_reg_i(vc_id_reg_i), .data_type_reg_i(data_type_reg_i),
    .clear_frame_sync_i(clear_frame_sync_i), .clear_frame_data_i(clear_frame_data_i),
    .clear_gsp_ovf_i(clear_gsp_ovf_i), .gsp_pop_i(gsp_pop_i),
    .activate_stream_o(activate_stream_o), .frame_valid_o(frame_valid_o), .line_valid_o(line_valid_o),
    .frame_num_o(frame_num_o), .line_num_o(line_num_o),
    .err_frame_sync_o(err_frame_sync_o), .err_frame_data_o(err_frame_data_o),
    .gsp_valid_o(gsp_valid_o), .gsp_code_o(gsp_code_o), .gsp_data_o(gsp_data_o), .gsp_ovf_o(gsp_ovf_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One header: valid for 'hold' cycles, then one idle cycle so the next header is a new event.
  task automatic applyStimulus(input logic [VW-1:0] vc, input logic [5:0] dt,
                               input logic [15:0] len, input int hold);
    vc_id_i = vc;
    data_type_i = dt;
    packet_length_i = len;
    packet_header_valid_i = 1'b1;
    repeat (hold) tick();
    packet_header_valid_i = 1'b0;
    tick();
  endtask

  initial begin
    reset_n_i = 1'b0;
    packet_header_valid_i = 1'b0;
    packet_length_i = '0;
    vc_id_i = '0;
    data_type_i = '0;
    err_crc_i = 1'b0;
    err_sot_sync_hs_i = 1'b0;
    err_ecc_double_i = 1'b0;
    stream_enable_i = 4'hF;
    vc_id_reg_i = {4'd3, 4'd5, 4'd1, 4'd0};
    data_type_reg_i = {6'h2A, 6'h2B, 6'h2A, 6'h2A};
    clear_frame_sync_i = '0;
    clear_frame_data_i = '0;
    clear_gsp_ovf_i = '0;
    gsp_pop_i = '0;
    #2;
    checkOutput("reset_frame_valid", frame_valid_o, 0);
    checkOutput("reset_gsp_valid", gsp_valid_o, 0);
    checkOutput("reset_activate", activate_stream_o, 0);
    tick();
    tick();
    reset_n_i = 1'b1;
    tick();

    $display("[TB] frame/line tracking on stream 2");
    applyStimulus(4'd5, DT_FS, 16'd7, 1);
    checkOutput("fs_frame_num2", frame_num_o[47:32], 16'd7);
    checkOutput("fs_frame_valid", frame_valid_o, 4'b0100);
    checkOutput("fs_line_num2", line_num_o[47:32], 16'd0);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(4'd5, DT_LS, 16'd0, 1);
      checkOutput("ls_auto_line_num2", line_num_o[47:32], k);
      checkOutput("ls_no_activate", activate_stream_o, 0);
    end
    checkOutput("ls_line_valid", line_valid_o, 4'b0100);
    vc_id_i = 4'd5;
    data_type_i = 6'h2B;
    packet_length_i = 16'd100;
    packet_header_valid_i = 1'b1;
    tick();
    checkOutput("long_activate", activate_stream_o, 4'b0100);
    tick();
    packet_header_valid_i = 1'b0;
    tick();
    checkOutput("long_deactivate", activate_stream_o, 0);
    applyStimulus(4'd5, DT_LE, 16'd0, 1);
    checkOutput("le_line_valid", line_valid_o, 0);
    applyStimulus(4'd5, DT_FE, 16'd0, 1);
    checkOutput("fe_frame_valid", frame_valid_o, 0);
    checkOutput("fe_no_sync_err", err_frame_sync_o, 0);

    $display("[TB] frame sync errors on stream 0");
    applyStimulus(4'd0, DT_FS, 16'd1, 1);
    checkOutput("first_fs_no_err", err_frame_sync_o, 0);
    applyStimulus(4'd0, DT_FS, 16'd2, 1);
    checkOutput("double_fs_err", err_frame_sync_o, 4'b0001);
    applyStimulus(4'd0, DT_FE, 16'd0, 1);
    clear_frame_sync_i = 4'b0001;
    tick();
    clear_frame_sync_i = '0;
    checkOutput("sync_err_cleared", err_frame_sync_o, 0);
    clear_frame_sync_i = 4'b0001;
    err_ecc_double_i = 1'b1;
    tick();
    clear_frame_sync_i = '0;
    err_ecc_double_i = 1'b0;
    checkOutput("set_wins_over_clear", err_frame_sync_o, 4'hF);
    clear_frame_sync_i = 4'hF;
    tick();
    clear_frame_sync_i = '0;
    checkOutput("sync_err_clear_all", err_frame_sync_o, 0);

    $display("[TB] payload CRC error on stream 2");
    applyStimulus(4'd5, DT_FS, 16'd8, 1);
    vc_id_i = 4'd5;
    data_type_i = 6'h2B;
    packet_header_valid_i = 1'b1;
    tick();
    err_crc_i = 1'b1;
    tick();
    err_crc_i = 1'b0;
    tick();
    packet_header_valid_i = 1'b0;
    tick();
    checkOutput("crc_before_fe", err_frame_data_o, 0);
    applyStimulus(4'd5, DT_FE, 16'd0, 1);
    checkOutput("crc_after_fe", err_frame_data_o, 4'b0100);
    applyStimulus(4'd5, DT_FS, 16'd9, 1);
    applyStimulus(4'd5, 6'h2B, 16'd10, 2);
    applyStimulus(4'd5, DT_FE, 16'd0, 1);
    checkOutput("data_err_sticky", err_frame_data_o, 4'b0100);
    clear_frame_data_i = 4'b0100;
    tick();
    clear_frame_data_i = '0;
    checkOutput("data_err_cleared", err_frame_data_o, 0);

    $display("[TB] GSP FIFO on stream 1");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'd1, 6'h08 + 6'(k), 16'h1000 + 16'(k), 1);
      if (k == 0) begin
        checkOutput("gsp_first_valid", gsp_valid_o, 4'b0010);
        checkOutput("gsp_first_data", gsp_data_o[31:16], 16'h1000);
      end
    end
    checkOutput("gsp_full_no_ovf", gsp_ovf_o, 0);
    applyStimulus(4'd1, 6'h08, 16'hDEAD, 1);
    checkOutput("gsp_ovf", gsp_ovf_o, 4'b0010);
    for (int k = 0; k < 8; k++) begin
      checkOutput("gsp_pop_valid", gsp_valid_o[1], 1'b1);
      checkOutput("gsp_pop_code", gsp_code_o[5:3], k);
      checkOutput("gsp_pop_data", gsp_data_o[31:16], 16'h1000 + k);
      gsp_pop_i = 4'b0010;
      tick();
      gsp_pop_i = '0;
    end
    checkOutput("gsp_empty", gsp_valid_o, 0);
    gsp_pop_i = 4'b0010;
    tick();
    gsp_pop_i = '0;
    checkOutput("gsp_pop_empty_ignored", gsp_valid_o, 0);
    clear_gsp_ovf_i = 4'b0010;
    tick();
    clear_gsp_ovf_i = '0;
    checkOutput("gsp_ovf_cleared", gsp_ovf_o, 0);

    $display("[TB] held header and line number wrap on stream 2");
    applyStimulus(4'd5, DT_LS, 16'd0, 5);
    checkOutput("held_ls_once", line_num_o[47:32], 16'd1);
    applyStimulus(4'd5, DT_LS, 16'hFFFF, 1);
    checkOutput("ls_explicit", line_num_o[47:32], 16'hFFFF);
    applyStimulus(4'd5, DT_LS, 16'd0, 1);
    checkOutput("ls_wrap", line_num_o[47:32], 16'h0000);

    $display("[TB] stream disable on stream 3");
    applyStimulus(4'd3, DT_FS, 16'd9, 1);
    applyStimulus(4'd3, 6'h0A, 16'h00AB, 1);
    checkOutput("s3_gsp_valid", gsp_valid_o, 4'b1000);
    stream_enable_i = 4'b0111;
    tick();
    checkOutput("disable_flush", gsp_valid_o, 0);
    checkOutput("disable_frame_num_held", frame_num_o[63:48], 16'd9);
    stream_enable_i = 4'hF;
    tick();
    applyStimulus(4'd3, DT_FE, 16'd0, 1);
    checkOutput("disable_fsm_idle", err_frame_sync_o, 4'b1000);

    $display("[TB] reset mid-frame");
    applyStimulus(4'd0, DT_FS, 16'd3, 1);
    applyStimulus(4'd0, DT_LS, 16'd5, 1);
    checkOutput("pre_reset_line_num0", line_num_o[15:0], 16'd5);
    #3;
    reset_n_i = 1'b0;
    #1;
    checkOutput("rst_frame_valid", frame_valid_o, 0);
    checkOutput("rst_line_valid", line_valid_o, 0);
    checkOutput("rst_frame_num", frame_num_o, 0);
    checkOutput("rst_line_num", line_num_o, 0);
    checkOutput("rst_sync_err", err_frame_sync_o, 0);
    tick();
    reset_n_i = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
